// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RV32I front-end pipeline registers.
package riscv_pipe_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic [2:0] ALUControl;
        logic       ALUSrc;
    } ctrl_t;

    localparam int          CTRL_W      = $bits(ctrl_t);
    localparam ctrl_t       CTRL_BUBBLE = '0;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register with enable and clear; a clear loads the reset value,
// so a flushed stage looks exactly like a freshly reset one.
module pipe_reg_en_clr #(
    parameter int             W       = 32,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_front_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage RV32I core under hazard-unit control,
// plus saturating counters of stall, flush and redirect events.
module pipeline_front_regs
    import riscv_pipe_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic             PCSrcE,
    input  logic [XLEN-1:0]  PCTargetE,
    input  logic [31:0]      InstrF,
    input  ctrl_t            CtrlD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             CntClr,
    output logic [XLEN-1:0]  PCF,
    output logic [31:0]      InstrD,
    output logic [XLEN-1:0]  PCD,
    output logic [XLEN-1:0]  PCPlus4D,
    output logic             ValidD,
    output logic             ValidE,
    output ctrl_t            CtrlE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] RedirCnt
);

    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int IFID_W = 32 + 2 * XLEN + 1;
    localparam int IDEX_W = CTRL_W + 5 * XLEN + 15 + 1;
    localparam logic [IFID_W-1:0] IFID_RST = {NOP_INSTR, {(2 * XLEN + 1){1'b0}}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             ev);
        if (ev && (cnt != CNT_MAX)) begin
            return cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

    logic [XLEN-1:0]   pc_plus4_p0;
    logic [XLEN-1:0]   pc_next_p0;
    logic [IFID_W-1:0] ifid_d_p1;
    logic [IFID_W-1:0] ifid_q_p1;
    logic [IDEX_W-1:0] idex_d_p2;
    logic [IDEX_W-1:0] idex_q_p2;

    // ---- Fetch: a redirect always wins over StallF so it can never be dropped
    assign pc_plus4_p0 = PCF + PC_STEP;
    assign pc_next_p0  = PCSrcE ? PCTargetE : pc_plus4_p0;

    pipe_reg_en_clr #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (PCSrcE | ~StallF),
        .clr     (1'b0),
        .d       (pc_next_p0),
        .q       (PCF)
    );

    // ---- IF/ID: flush loads the NOP bubble and takes priority over StallD
    assign ifid_d_p1 = {InstrF, PCF, pc_plus4_p0, 1'b1};

    pipe_reg_en_clr #(.W(IFID_W), .RST_VAL(IFID_RST)) u_ifid_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (~StallD),
        .clr     (FlushD),
        .d       (ifid_d_p1),
        .q       (ifid_q_p1)
    );

    assign {InstrD, PCD, PCPlus4D, ValidD} = ifid_q_p1;

    // ---- ID/EX: never stalls, only bubbled by FlushE
    assign idex_d_p2 = {CtrlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ValidD};

    pipe_reg_en_clr #(.W(IDEX_W), .RST_VAL('0)) u_idex_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (1'b1),
        .clr     (FlushE),
        .d       (idex_d_p2),
        .q       (idex_q_p2)
    );

    assign {CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE} = idex_q_p2;

    always_ff @(posedge clk) begin
        if (!reset_n || CntClr) begin
            StallCnt <= '0;
            FlushCnt <= '0;
            RedirCnt <= '0;
        end else begin
            StallCnt <= sat_inc(StallCnt, StallF);
            FlushCnt <= sat_inc(FlushCnt, FlushE);
            RedirCnt <= sat_inc(RedirCnt, PCSrcE);
        end
    end

endmodule

// File: tb/tb_pipeline_front_regs.sv
// Scoreboard bench for pipeline_front_regs: fetch/decode records flow through queues.
module tb_pipeline_front_regs;
    import riscv_pipe_pkg::*;

    localparam int          XLEN  = 32;
    localparam int          CNT_W = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, StallF, StallD, FlushD, FlushE, PCSrcE, CntClr;
    logic [31:0] PCTargetE, InstrF, RD1D, RD2D, ImmExtD;
    ctrl_t CtrlD, CtrlE;
    logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D, RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic ValidD, ValidE;
    logic [CNT_W-1:0] StallCnt, FlushCnt, RedirCnt;

    pipeline_front_regs #(.XLEN(XLEN), .RESET_PC(RPC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .InstrF(InstrF), .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .CntClr(CntClr),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .ValidE(ValidE), .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E),
        .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt), .RedirCnt(RedirCnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } rec_t;

    rec_t qd[$];
    rec_t qe[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_pc;

    function automatic logic [31:0] imem(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h0000_0093;
    endfunction
    function automatic ctrl_t dctrl(input logic [31:0] i);
        return ctrl_t'(i[31:22]);
    endfunction
    function automatic logic [31:0] drd1(input logic [31:0] i);
        return i ^ 32'hA5A5_5A5A;
    endfunction
    function automatic logic [31:0] drd2(input logic [31:0] i);
        return {i[15:0], i[31:16]};
    endfunction
    function automatic logic [31:0] dimm(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    // Fetch and decode stimulus follow whatever the pipeline currently presents
    task automatic drive_inputs();
        InstrF  = imem(PCF);
        CtrlD   = dctrl(InstrD);
        RD1D    = drd1(InstrD);
        RD2D    = drd2(InstrD);
        ImmExtD = dimm(InstrD);
        Rs1D    = InstrD[19:15];
        Rs2D    = InstrD[24:20];
        RdD     = InstrD[11:7];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic clear_ctrl();
        StallF = 0; StallD = 0; FlushD = 0; FlushE = 0; PCSrcE = 0; CntClr = 0;
        PCTargetE = 32'h0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        clear_ctrl();
        tick();
        reset_n = 1;
    endtask

    task automatic prime(input logic [31:0] pc);
        rec_t r;
        qd.delete();
        qe.delete();
        exp_pc = pc;
        r.pc = pc;
        r.instr = imem(pc);
        qd.push_back(r);
    endtask

    task automatic stream_cycle();
        rec_t r;
        tick();
        exp_pc = exp_pc + 32'd4;
        n_tests++; if (PCF !== exp_pc) begin n_fail++; $display("FAIL stream_pcf: got %h want %h", PCF, exp_pc); end
        if (qe.size() > 0) begin
            r = qe.pop_front();
            n_tests++; if (CtrlE !== dctrl(r.instr)) begin n_fail++; $display("FAIL stream_ctrle: got %h want %h", CtrlE, dctrl(r.instr)); end
            n_tests++; if ({Rs1E, Rs2E, RdE} !== {r.instr[19:15], r.instr[24:20], r.instr[11:7]}) begin n_fail++; $display("FAIL stream_idx_e: got %h want %h", {Rs1E, Rs2E, RdE}, {r.instr[19:15], r.instr[24:20], r.instr[11:7]}); end
            n_tests++; if ({RD1E, RD2E, ImmExtE} !== {drd1(r.instr), drd2(r.instr), dimm(r.instr)}) begin n_fail++; $display("FAIL stream_data_e: got %h want %h", {RD1E, RD2E, ImmExtE}, {drd1(r.instr), drd2(r.instr), dimm(r.instr)}); end
            n_tests++; if ({PCE, PCPlus4E} !== {r.pc, r.pc + 32'd4}) begin n_fail++; $display("FAIL stream_pc_e: got %h want %h", {PCE, PCPlus4E}, {r.pc, r.pc + 32'd4}); end
            n_tests++; if (ValidE !== 1'b1) begin n_fail++; $display("FAIL stream_valid_e: got %b want 1", ValidE); end
        end
        if (qd.size() > 0) begin
            r = qd.pop_front();
            n_tests++; if (InstrD !== r.instr) begin n_fail++; $display("FAIL stream_instrd: got %h want %h", InstrD, r.instr); end
            n_tests++; if ({PCD, PCPlus4D} !== {r.pc, r.pc + 32'd4}) begin n_fail++; $display("FAIL stream_pc_d: got %h want %h", {PCD, PCPlus4D}, {r.pc, r.pc + 32'd4}); end
            n_tests++; if (ValidD !== 1'b1) begin n_fail++; $display("FAIL stream_valid_d: got %b want 1", ValidD); end
            qe.push_back(r);
        end
        r.pc = exp_pc;
        r.instr = imem(exp_pc);
        qd.push_back(r);
    endtask

    task automatic test_reset();
        reset_n = 0;
        clear_ctrl();
        StallF = 1; FlushD = 1; PCSrcE = 1; PCTargetE = 32'hDEAD_BEE0;
        tick();
        tick();
        n_tests++; if (PCF !== RPC) begin n_fail++; $display("FAIL reset_pcf: got %h want %h", PCF, RPC); end
        n_tests++; if (InstrD !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instrd: got %h want 00000013", InstrD); end
        n_tests++; if ({PCD, PCPlus4D, ValidD, ValidE} !== 66'h0) begin n_fail++; $display("FAIL reset_d_valid: got %h want 0", {PCD, PCPlus4D, ValidD, ValidE}); end
        n_tests++; if (CtrlE !== 10'h0) begin n_fail++; $display("FAIL reset_ctrle: got %h want 0", CtrlE); end
        n_tests++; if ({RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE} !== 175'h0) begin n_fail++; $display("FAIL reset_e_data: got %h want 0", {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE}); end
        n_tests++; if ({StallCnt, FlushCnt, RedirCnt} !== 12'h0) begin n_fail++; $display("FAIL reset_counters: got %h want 0", {StallCnt, FlushCnt, RedirCnt}); end
        reset_n = 1;
        clear_ctrl();
        tick();
        n_tests++; if (PCF !== 32'h104) begin n_fail++; $display("FAIL release_pc1: got %h want 00000104", PCF); end
        tick();
        n_tests++; if (PCF !== 32'h108) begin n_fail++; $display("FAIL release_pc2: got %h want 00000108", PCF); end
    endtask

    task automatic test_straight_line();
        do_reset();
        prime(RPC);
        repeat (6) stream_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        prime(RPC);
        repeat (3) stream_cycle();
        StallF = 1; StallD = 1; FlushE = 1;
        tick();
        n_tests++; if (PCF !== exp_pc) begin n_fail++; $display("FAIL lu_pcf: got %h want %h", PCF, exp_pc); end
        n_tests++; if ({InstrD, PCD, ValidD} !== {imem(exp_pc - 32'd4), exp_pc - 32'd4, 1'b1}) begin n_fail++; $display("FAIL lu_ifid_hold: got %h want %h", {InstrD, PCD, ValidD}, {imem(exp_pc - 32'd4), exp_pc - 32'd4, 1'b1}); end
        n_tests++; if ({CtrlE, RdE, ValidE} !== 16'h0) begin n_fail++; $display("FAIL lu_bubble_e: got %h want 0", {CtrlE, RdE, ValidE}); end
        n_tests++; if ({StallCnt, FlushCnt, RedirCnt} !== 12'h110) begin n_fail++; $display("FAIL lu_counters: got %h want 110", {StallCnt, FlushCnt, RedirCnt}); end
        clear_ctrl();
        repeat (2) stream_cycle();
    endtask

    task automatic test_redirect();
        do_reset();
        prime(RPC);
        repeat (3) stream_cycle();
        PCSrcE = 1; PCTargetE = 32'h40; FlushD = 1; FlushE = 1; StallF = 1;
        tick();
        n_tests++; if (PCF !== 32'h40) begin n_fail++; $display("FAIL redir_pcf: got %h want 00000040", PCF); end
        n_tests++; if (InstrD !== 32'h0000_0013) begin n_fail++; $display("FAIL redir_instrd: got %h want 00000013", InstrD); end
        n_tests++; if ({PCD, PCPlus4D, ValidD, ValidE} !== 66'h0) begin n_fail++; $display("FAIL redir_bubbles: got %h want 0", {PCD, PCPlus4D, ValidD, ValidE}); end
        n_tests++; if (CtrlE !== 10'h0) begin n_fail++; $display("FAIL redir_ctrle: got %h want 0", CtrlE); end
        n_tests++; if ({StallCnt, FlushCnt, RedirCnt} !== 12'h111) begin n_fail++; $display("FAIL redir_counters: got %h want 111", {StallCnt, FlushCnt, RedirCnt}); end
        clear_ctrl();
        prime(32'h40);
        stream_cycle();
        n_tests++; if (ValidE !== 1'b0) begin n_fail++; $display("FAIL redir_valid_e_after: got %b want 0", ValidE); end
        repeat (2) stream_cycle();
    endtask

    task automatic test_flush_over_stall();
        do_reset();
        prime(RPC);
        repeat (3) stream_cycle();
        FlushD = 1; StallD = 1; StallF = 1;
        tick();
        n_tests++; if (InstrD !== 32'h0000_0013) begin n_fail++; $display("FAIL fos_instrd: got %h want 00000013", InstrD); end
        n_tests++; if ({PCD, PCPlus4D, ValidD} !== 65'h0) begin n_fail++; $display("FAIL fos_d_zero: got %h want 0", {PCD, PCPlus4D, ValidD}); end
        n_tests++; if (PCF !== exp_pc) begin n_fail++; $display("FAIL fos_pcf: got %h want %h", PCF, exp_pc); end
        n_tests++; if ({ValidE, PCE} !== {1'b1, exp_pc - 32'd4}) begin n_fail++; $display("FAIL fos_e_capture: got %h want %h", {ValidE, PCE}, {1'b1, exp_pc - 32'd4}); end
        clear_ctrl();
    endtask

    task automatic test_counters();
        do_reset();
        StallF = 1; StallD = 1;
        repeat (10) tick();
        n_tests++; if (StallCnt !== 4'd10) begin n_fail++; $display("FAIL cnt_stall_10: got %0d want 10", StallCnt); end
        repeat (10) tick();
        n_tests++; if ({StallCnt, FlushCnt, RedirCnt} !== 12'hF00) begin n_fail++; $display("FAIL cnt_stall_sat: got %h want f00", {StallCnt, FlushCnt, RedirCnt}); end
        CntClr = 1;
        tick();
        n_tests++; if (StallCnt !== 4'd0) begin n_fail++; $display("FAIL cnt_clr: got %0d want 0", StallCnt); end
        CntClr = 0;
        tick();
        n_tests++; if (StallCnt !== 4'd1) begin n_fail++; $display("FAIL cnt_after_clr: got %0d want 1", StallCnt); end
        FlushE = 1; PCSrcE = 1; PCTargetE = 32'h200;
        repeat (17) tick();
        n_tests++; if ({StallCnt, FlushCnt, RedirCnt} !== 12'hFFF) begin n_fail++; $display("FAIL cnt_all_sat: got %h want fff", {StallCnt, FlushCnt, RedirCnt}); end
        CntClr = 1;
        tick();
        n_tests++; if ({StallCnt, FlushCnt, RedirCnt} !== 12'h000) begin n_fail++; $display("FAIL cnt_clr_priority: got %h want 000", {StallCnt, FlushCnt, RedirCnt}); end
        clear_ctrl();
    endtask

    task automatic test_midrun_reset();
        do_reset();
        prime(RPC);
        repeat (4) stream_cycle();
        StallF = 1; StallD = 1;
        tick();
        reset_n = 0;
        tick();
        n_tests++; if (PCF !== RPC) begin n_fail++; $display("FAIL mid_pcf: got %h want %h", PCF, RPC); end
        n_tests++; if ({InstrD, ValidD, ValidE} !== {32'h0000_0013, 2'b00}) begin n_fail++; $display("FAIL mid_stage_state: got %h want %h", {InstrD, ValidD, ValidE}, {32'h0000_0013, 2'b00}); end
        n_tests++; if ({CtrlE, PCE, PCD} !== 74'h0) begin n_fail++; $display("FAIL mid_pipe_zero: got %h want 0", {CtrlE, PCE, PCD}); end
        n_tests++; if (StallCnt !== 4'd0) begin n_fail++; $display("FAIL mid_counter: got %0d want 0", StallCnt); end
        reset_n = 1;
        clear_ctrl();
    endtask

    initial begin
        reset_n = 0;
        clear_ctrl();
        InstrF = 32'h0; CtrlD = '0; RD1D = '0; RD2D = '0; ImmExtD = '0;
        Rs1D = '0; Rs2D = '0; RdD = '0;
        test_reset();
        test_straight_line();
        test_load_use();
        test_redirect();
        test_flush_over_stall();
        test_counters();
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
